// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared control-transfer definitions for the EX-stage redirect logic.
// Opcode/funct3 encodings and the redirect FSM state type.
package riscv_ctrl_pkg;

    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        IDLE,
        REDIR
    } redir_state_e;

    function automatic logic is_ctl_op(input logic [4:0] op);
        return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
    endfunction

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// EX-stage control-transfer bundle: resolved instruction in, redirect/trap/stats out.
// master = pipeline/fetch side driving EX operands; slave = redirect controller.
interface branch_redirect_ctrl_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
);
    logic             ex_valid;
    logic [4:0]       ex_opcode;
    logic [2:0]       ex_f3;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_imm;
    logic [XLEN-1:0]  ex_rs1;
    logic             cmp;
    logic             fetch_ready;
    logic             flush;
    logic             ex_stall;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             trap_valid;
    logic [XLEN-1:0]  trap_pc;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] taken_count;

    modport master (
        output ex_valid, ex_opcode, ex_f3, ex_pc, ex_imm, ex_rs1, cmp, fetch_ready,
        input  flush, ex_stall, redirect_valid, redirect_pc, trap_valid, trap_pc,
               br_count, taken_count
    );

    modport slave (
        input  ex_valid, ex_opcode, ex_f3, ex_pc, ex_imm, ex_rs1, cmp, fetch_ready,
        output flush, ex_stall, redirect_valid, redirect_pc, trap_valid, trap_pc,
               br_count, taken_count
    );

endinterface

// File: rtl/branch_redirect_ctrl_target.sv
// Control-transfer target computation: PC- or rs1-relative sum, JALR LSB clear,
// and word-misalignment flag (no compressed instructions).
module branch_target
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [4:0]      opcode,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);

    logic            is_jalr;
    logic [XLEN-1:0] sum;

    always_comb begin
        is_jalr    = (opcode == OP_JALR);
        sum        = (is_jalr ? rs1 : pc) + imm;
        target     = is_jalr ? {sum[XLEN-1:1], 1'b0} : sum;
        misaligned = target[1];
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// EX-stage redirect controller: flushes the wrong path, holds a redirect until fetch
// accepts it, raises misaligned-target traps and counts control instructions.
module branch_redirect_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    branch_redirect_ctrl_if.slave bus
);

    redir_state_e    state, state_nxt;
    logic [XLEN-1:0] target;
    logic            misaligned;
    logic            accept;
    logic            ctl_op;
    logic            take;

    branch_target #(
        .XLEN(XLEN)
    ) u_target (
        .opcode     (bus.ex_opcode),
        .pc         (bus.ex_pc),
        .imm        (bus.ex_imm),
        .rs1        (bus.ex_rs1),
        .target     (target),
        .misaligned (misaligned)
    );

    // EX is only evaluated in IDLE; while a redirect is pending the instruction is stalled.
    always_comb begin
        accept = (state == IDLE);
        ctl_op = accept & bus.ex_valid & is_ctl_op(bus.ex_opcode);
        take   = ctl_op & bus.cmp;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (take && !misaligned) state_nxt = REDIR;
            REDIR:   if (bus.fetch_ready)     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.flush          = rst_n & take;
        bus.ex_stall       = rst_n & (state == REDIR) & bus.ex_valid;
        bus.redirect_valid = (state == REDIR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.redirect_pc <= '0;
            bus.trap_valid  <= 1'b0;
            bus.trap_pc     <= '0;
            bus.br_count    <= '0;
            bus.taken_count <= '0;
        end else begin
            bus.trap_valid <= take & misaligned;
            if (take && !misaligned) bus.redirect_pc <= target;
            if (take && misaligned)  bus.trap_pc     <= bus.ex_pc;
            if (ctl_op)              bus.br_count    <= bus.br_count + 1'b1;
            if (take)                bus.taken_count <= bus.taken_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl with a narrow counter width to exercise wrap.
module tb_branch_redirect_ctrl;
    import riscv_ctrl_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    branch_redirect_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    branch_redirect_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] rs1, input logic c);
        bus.ex_valid  = v;
        bus.ex_opcode = op;
        bus.ex_f3     = f3;
        bus.ex_pc     = pc;
        bus.ex_imm    = imm;
        bus.ex_rs1    = rs1;
        bus.cmp       = c;
        #1;
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.fetch_ready = 1'b0;
        drive(1'b0, 5'b0, 3'b0, 32'h0, 32'h0, 32'h0, 1'b0);

        // reset values
        #3;
        chk("rst_rv",    bus.redirect_valid, 1'b0);
        chk("rst_rpc",   bus.redirect_pc, 32'h0);
        chk("rst_tv",    bus.trap_valid, 1'b0);
        chk("rst_tpc",   bus.trap_pc, 32'h0);
        chk("rst_br",    bus.br_count, 4'd0);
        chk("rst_tk",    bus.taken_count, 4'd0);
        chk("rst_flush", bus.flush, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        // BEQ taken, fetch ready immediately
        bus.fetch_ready = 1'b1;
        drive(1'b1, OP_BRANCH, F3_BEQ, 32'h100, 32'h20, 32'h0, 1'b1);
        chk("beq_flush", bus.flush, 1'b1);
        chk("beq_stall", bus.ex_stall, 1'b0);
        tick();
        drive(1'b0, OP_BRANCH, F3_BEQ, 32'h100, 32'h20, 32'h0, 1'b1);
        chk("beq_rv",   bus.redirect_valid, 1'b1);
        chk("beq_rpc",  bus.redirect_pc, 32'h120);
        chk("beq_br",   bus.br_count, 4'd1);
        chk("beq_tk",   bus.taken_count, 4'd1);
        chk("beq_fl2",  bus.flush, 1'b0);
        tick();
        chk("beq_idle", bus.redirect_valid, 1'b0);

        // BNE not taken
        drive(1'b1, OP_BRANCH, F3_BNE, 32'h200, 32'h40, 32'h0, 1'b0);
        chk("bne_flush", bus.flush, 1'b0);
        tick();
        drive(1'b0, OP_BRANCH, F3_BNE, 32'h200, 32'h40, 32'h0, 1'b0);
        chk("bne_rv", bus.redirect_valid, 1'b0);
        chk("bne_br", bus.br_count, 4'd2);
        chk("bne_tk", bus.taken_count, 4'd1);

        // JALR with slow fetch; a taken BEQ waits behind it
        bus.fetch_ready = 1'b0;
        drive(1'b1, OP_JALR, 3'b000, 32'h500, 32'h4, 32'h2001, 1'b1);
        chk("jalr_flush", bus.flush, 1'b1);
        tick();
        drive(1'b1, OP_BRANCH, F3_BEQ, 32'h300, 32'h8, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("jalr_rv",    bus.redirect_valid, 1'b1);
            chk("jalr_rpc",   bus.redirect_pc, 32'h2004);
            chk("jalr_stall", bus.ex_stall, 1'b1);
            chk("jalr_nofl",  bus.flush, 1'b0);
            tick();
        end
        bus.fetch_ready = 1'b1;
        #1;
        chk("jalr_rv6",  bus.redirect_valid, 1'b1);
        chk("jalr_rpc6", bus.redirect_pc, 32'h2004);
        chk("jalr_br",   bus.br_count, 4'd3);
        chk("jalr_tk",   bus.taken_count, 4'd2);
        tick();
        chk("b2b_rv",    bus.redirect_valid, 1'b0);
        chk("b2b_flush", bus.flush, 1'b1);
        chk("b2b_stall", bus.ex_stall, 1'b0);
        tick();
        drive(1'b0, OP_BRANCH, F3_BEQ, 32'h300, 32'h8, 32'h0, 1'b1);
        chk("b2b_rpc", bus.redirect_pc, 32'h308);
        chk("b2b_br",  bus.br_count, 4'd4);
        chk("b2b_tk",  bus.taken_count, 4'd3);
        tick();

        // JAL to a misaligned target
        drive(1'b1, OP_JAL, 3'b000, 32'h100, 32'h6, 32'h0, 1'b1);
        chk("jal_flush", bus.flush, 1'b1);
        tick();
        drive(1'b0, OP_JAL, 3'b000, 32'h100, 32'h6, 32'h0, 1'b1);
        chk("jal_tv",  bus.trap_valid, 1'b1);
        chk("jal_tpc", bus.trap_pc, 32'h100);
        chk("jal_rv",  bus.redirect_valid, 1'b0);
        chk("jal_br",  bus.br_count, 4'd5);
        chk("jal_tk",  bus.taken_count, 4'd4);
        tick();
        chk("jal_tv0", bus.trap_valid, 1'b0);

        // non-control opcode is ignored
        drive(1'b1, 5'b01100, 3'b000, 32'h100, 32'h20, 32'h0, 1'b1);
        chk("alu_flush", bus.flush, 1'b0);
        tick();
        drive(1'b0, 5'b01100, 3'b000, 32'h100, 32'h20, 32'h0, 1'b1);
        chk("alu_br", bus.br_count, 4'd5);
        chk("alu_rv", bus.redirect_valid, 1'b0);

        // reset in the middle of a pending redirect
        bus.fetch_ready = 1'b0;
        drive(1'b1, OP_BRANCH, F3_BEQ, 32'h400, 32'h10, 32'h0, 1'b1);
        tick();
        chk("mid_rv", bus.redirect_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rv",    bus.redirect_valid, 1'b0);
        chk("mid_rst_rpc",   bus.redirect_pc, 32'h0);
        chk("mid_rst_stall", bus.ex_stall, 1'b0);
        chk("mid_rst_flush", bus.flush, 1'b0);
        chk("mid_rst_br",    bus.br_count, 4'd0);
        tick();
        drive(1'b0, OP_BRANCH, F3_BEQ, 32'h400, 32'h10, 32'h0, 1'b1);
        rst_n = 1'b1;
        tick();

        // first scenario again after reset
        bus.fetch_ready = 1'b1;
        drive(1'b1, OP_BRANCH, F3_BEQ, 32'h100, 32'h20, 32'h0, 1'b1);
        chk("re_flush", bus.flush, 1'b1);
        tick();
        drive(1'b0, OP_BRANCH, F3_BEQ, 32'h100, 32'h20, 32'h0, 1'b1);
        chk("re_rpc", bus.redirect_pc, 32'h120);
        chk("re_br",  bus.br_count, 4'd1);
        chk("re_tk",  bus.taken_count, 4'd1);
        tick();
        chk("re_idle", bus.redirect_valid, 1'b0);

        // counter wrap via back-to-back misaligned taken JALs (stay in IDLE)
        drive(1'b1, OP_JAL, 3'b000, 32'h800, 32'h2, 32'h0, 1'b1);
        for (int i = 0; i < 14; i++) tick();
        chk("pre_wrap_br", bus.br_count, 4'd15);
        chk("pre_wrap_tk", bus.taken_count, 4'd15);
        tick();
        drive(1'b0, OP_JAL, 3'b000, 32'h800, 32'h2, 32'h0, 1'b1);
        chk("wrap_br",  bus.br_count, 4'd0);
        chk("wrap_tk",  bus.taken_count, 4'd0);
        chk("wrap_tpc", bus.trap_pc, 32'h800);

        // target sum wraps modulo 2^XLEN
        drive(1'b1, OP_BRANCH, F3_BLTU, 32'hFFFF_FFF0, 32'h20, 32'h0, 1'b1);
        tick();
        drive(1'b0, OP_BRANCH, F3_BLTU, 32'hFFFF_FFF0, 32'h20, 32'h0, 1'b1);
        chk("ovf_rpc", bus.redirect_pc, 32'h10);
        chk("ovf_rv",  bus.redirect_valid, 1'b1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Sequences control transfers resolved in the EX stage of the RISC-V core. It consumes the branch-compare result together with the decoded opcode, funct3, PC, immediate and rs1, computes the target, and flushes the wrong-path front end. It holds a redirect request toward fetch until fetch accepts it, which may take many cycles while the I-cache services a miss. It also raises misaligned-target traps and keeps branch statistics counters.

## Interface
Parameters:
- XLEN, 32, datapath/PC width
- CNT_W, 32, statistics counter width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ex_valid  in  1  EX holds a valid instruction
- ex_opcode  in  5  instr[6:2]
- ex_f3  in  3  funct3
- ex_pc  in  XLEN  PC of EX instruction
- ex_imm  in  XLEN  sign-extended immediate
- ex_rs1  in  XLEN  rs1 operand (JALR base)
- cmp  in  1  branch condition from compare unit (1 = condition true; forced 1 for JAL/JALR)
- fetch_ready  in  1  fetch accepts redirect this cycle
- flush  out  1  kill IF/ID and ID/EX contents at next edge (combinational)
- ex_stall  out  1  hold EX; redirect still pending
- redirect_valid  out  1  redirect request to fetch
- redirect_pc  out  XLEN  new fetch PC
- trap_valid  out  1  one-cycle misaligned-target trap pulse
- trap_pc  out  XLEN  PC of faulting instruction
- br_count  out  CNT_W  control instructions retired
- taken_count  out  CNT_W  taken control instructions

## Operation
- Control op: ex_opcode is 11000 (branch), 11011 (JAL) or 11001 (JALR). Any other opcode is ignored.
- Taken: `ctl = ex_valid & control op & cmp`.
- Target:
  - Branch and JAL: `ex_pc + ex_imm`.
  - JALR: `(ex_rs1 + ex_imm) & ~1`.
  - All sums are mod 2^XLEN; overflow wraps silently.
- Misaligned: `target[1] != 0` (no C extension).
- States:
  - IDLE: no redirect outstanding.
  - REDIR: redirect_valid = 1, redirect_pc held stable.
- IDLE transitions:
  - Accepted control op, taken, aligned: flush = 1 this cycle; go to REDIR with redirect_pc = target.
  - Accepted control op, taken, misaligned: flush = 1; trap_valid = 1 next cycle with trap_pc = ex_pc; stay IDLE; no redirect.
  - Not taken: no action apart from counters.
- REDIR transitions:
  - fetch_ready = 1: return to IDLE next edge.
  - fetch_ready = 0: stay in REDIR, outputs held.
  - ex_stall = 1 while in REDIR and ex_valid = 1. EX inputs are ignored during this time: no flush, no counting, no trap.
- Counters: accepted means evaluated in IDLE.
  - br_count += 1 per accepted control op.
  - taken_count += 1 per accepted taken op, including misaligned ones.
  - Both wrap modulo 2^CNT_W.
- Reset (asynchronous, any state, including mid-REDIR):
  - State returns to IDLE.
  - redirect_valid = 0, redirect_pc = 0, trap_valid = 0, trap_pc = 0, counters = 0.
  - The pending redirect is dropped.
- flush and ex_stall are combinational. While rst_n = 0 they are forced to 0.

## Timing
- Taken decision at cycle N:
  - flush high during N.
  - redirect_valid high from N+1.
  - Earliest return to IDLE is the edge ending N+1, when fetch_ready is 1 at N+1.
- Redirect handshake: a transfer occurs on a cycle where redirect_valid & fetch_ready. redirect_pc must not change while redirect_valid = 1 and not yet accepted.
- fetch_ready has no effect in IDLE.
- Back-to-back taken ops: the second is stalled until the cycle after acceptance. Minimum spacing between redirects is 2 cycles.
- Trap: trap_valid is exactly one cycle (N+1), then 0.
- Counters update at the edge ending the accepting cycle.

## Structure
- Shared package riscv_ctrl_pkg holds:
  - OP_BRANCH = 5'b11000, OP_JAL = 5'b11011, OP_JALR = 5'b11001.
  - funct3 branch codes: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111.
  - State enum {IDLE, REDIR}.
- One sub-module, branch_target: combinational target adder, JALR LSB clear, and misalign flag.
- The FSM, counters and trap register stay in the top module.

## Test plan
- BEQ, cmp = 1, ex_pc = 0x100, imm = 0x20, fetch_ready = 1 → flush at N; redirect_valid at N+1 with redirect_pc = 0x120; IDLE at N+2; br_count = 1, taken_count = 1.
- BNE, cmp = 0 → no flush, no redirect; br_count = 1, taken_count = 0.
- JALR, rs1 = 0x2001, imm = 0x4 → redirect_pc = 0x2004. Hold fetch_ready = 0 for 5 cycles → redirect_pc stable; ex_stall = 1 whenever ex_valid; accepted on the 6th cycle.
- JAL, ex_pc = 0x100, imm = 0x6 → target 0x106 is misaligned: flush = 1, trap_valid one-cycle pulse with trap_pc = 0x100, redirect_valid stays 0.
- Deassert rst_n during REDIR → all outputs 0 immediately; after release, state is IDLE and the next BEQ taken behaves as in the first scenario.
- Preload counters to 2^CNT_W − 1 via a sequence of taken ops (or force), then one more taken op → both counters wrap to 0.
